// File: rtl/riscv_core_rob_pkg.sv
// riscv_core_rob_pkg: shared reorder-buffer constants, entry layout and pointer helper
package riscv_core_rob_pkg;
    localparam int ROB_DEPTH  = 32;
    localparam int ROB_SLOT_W = 5;
    localparam int ROB_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  wen;
        logic [4:0]            waddr;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

    function automatic logic [ROB_SLOT_W-1:0] ptr_inc(input logic [ROB_SLOT_W-1:0] p, input logic [1:0] n);
        return p + ROB_SLOT_W'(n);
    endfunction
endpackage

// File: rtl/riscv_core_rob_commit_sel.sv
// riscv_core_rob_commit_sel: in-order retirement select for the head and head+1 entries
module riscv_core_rob_commit_sel
    import riscv_core_rob_pkg::*;
(
    input  logic [ROB_SLOT_W-1:0] head,
    input  rob_entry_t            head_ent,
    input  rob_entry_t            next_ent,
    output logic                  c1,
    output logic                  c2,
    output logic [ROB_SLOT_W-1:0] slot1,
    output logic [ROB_SLOT_W-1:0] slot2,
    output logic                  wen1,
    output logic                  wen2,
    output logic [4:0]            waddr1,
    output logic [4:0]            waddr2,
    output logic [ROB_DATA_W-1:0] wdata1,
    output logic [ROB_DATA_W-1:0] wdata2
);
    assign c1     = head_ent.valid & head_ent.done;
    assign c2     = c1 & next_ent.valid & next_ent.done;
    assign slot1  = head;
    assign slot2  = ptr_inc(head, 2'd1);
    assign wen1   = head_ent.wen;
    assign wen2   = next_ent.wen;
    assign waddr1 = head_ent.waddr;
    assign waddr2 = next_ent.waddr;
    assign wdata1 = head_ent.data;
    assign wdata2 = next_ent.data;
endmodule

// File: rtl/riscv_core_reorder_buffer.sv
// riscv_core_reorder_buffer: dual-wide in-order reorder buffer with two fill ports and two-wide commit
module riscv_core_reorder_buffer
    import riscv_core_rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int SLOT_W = ROB_SLOT_W,
    parameter int DATA_W = ROB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc0_req,
    input  logic              alloc1_req,
    output logic [SLOT_W-1:0] alloc0_slot,
    output logic [SLOT_W-1:0] alloc1_slot,
    output logic              rob_stall,
    input  logic              fillA_val,
    input  logic [SLOT_W-1:0] fillA_slot,
    input  logic              fillA_wen,
    input  logic [4:0]        fillA_waddr,
    input  logic [DATA_W-1:0] fillA_wdata,
    input  logic              fillB_val,
    input  logic [SLOT_W-1:0] fillB_slot,
    input  logic              fillB_wen,
    input  logic [4:0]        fillB_waddr,
    input  logic [DATA_W-1:0] fillB_wdata,
    output logic              rob_commit_val_1,
    output logic [SLOT_W-1:0] rob_commit_slot_1,
    output logic              rob_commit_wen_1,
    output logic [4:0]        rob_commit_waddr_1,
    output logic [DATA_W-1:0] rob_commit_wdata_1,
    output logic              rob_commit_val_2,
    output logic [SLOT_W-1:0] rob_commit_slot_2,
    output logic              rob_commit_wen_2,
    output logic [4:0]        rob_commit_waddr_2,
    output logic [DATA_W-1:0] rob_commit_wdata_2,
    input  logic [SLOT_W-1:0] rob_rd0_slot,
    input  logic [SLOT_W-1:0] rob_rd1_slot,
    output logic [DATA_W-1:0] rob_rd0_data,
    output logic [DATA_W-1:0] rob_rd1_data
);
    logic [SLOT_W-1:0] head, tail, head_p1;
    logic [SLOT_W:0]   count;
    logic [DEPTH-1:0]  valid, done, valid_nxt, done_nxt, wen;
    logic [4:0]        waddr [DEPTH];
    logic [DATA_W-1:0] data  [DEPTH];
    logic              a0, a1, fill_a, fill_b;
    logic [1:0]        n_alloc, n_commit;
    rob_entry_t        head_ent, next_ent;

    assign rob_stall    = count > (SLOT_W+1)'(DEPTH-2);
    assign a0           = alloc0_req & ~rob_stall;
    assign a1           = alloc1_req & ~rob_stall;
    assign alloc0_slot  = tail;
    assign alloc1_slot  = tail + SLOT_W'(alloc0_req);
    assign n_alloc      = 2'(a0) + 2'(a1);
    assign n_commit     = 2'(rob_commit_val_1) + 2'(rob_commit_val_2);
    assign fill_a       = fillA_val & valid[fillA_slot];
    assign fill_b       = fillB_val & valid[fillB_slot];
    assign head_p1      = ptr_inc(head, 2'd1);
    assign head_ent     = {valid[head], done[head], wen[head], waddr[head], data[head]};
    assign next_ent     = {valid[head_p1], done[head_p1], wen[head_p1], waddr[head_p1], data[head_p1]};
    assign rob_rd0_data = data[rob_rd0_slot];
    assign rob_rd1_data = data[rob_rd1_slot];

    riscv_core_rob_commit_sel u_commit_sel (
        .head     (head),
        .head_ent (head_ent),
        .next_ent (next_ent),
        .c1       (rob_commit_val_1),
        .c2       (rob_commit_val_2),
        .slot1    (rob_commit_slot_1),
        .slot2    (rob_commit_slot_2),
        .wen1     (rob_commit_wen_1),
        .wen2     (rob_commit_wen_2),
        .waddr1   (rob_commit_waddr_1),
        .waddr2   (rob_commit_waddr_2),
        .wdata1   (rob_commit_wdata_1),
        .wdata2   (rob_commit_wdata_2)
    );

    // Next status bits: fills complete live entries, commits retire, allocations open fresh entries
    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        if (fill_b) done_nxt[fillB_slot] = 1'b1;
        if (fill_a) done_nxt[fillA_slot] = 1'b1;
        if (rob_commit_val_1) begin
            valid_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
        if (rob_commit_val_2) begin
            valid_nxt[head_p1] = 1'b0;
            done_nxt[head_p1]  = 1'b0;
        end
        if (a0) begin
            valid_nxt[alloc0_slot] = 1'b1;
            done_nxt[alloc0_slot]  = 1'b0;
        end
        if (a1) begin
            valid_nxt[alloc1_slot] = 1'b1;
            done_nxt[alloc1_slot]  = 1'b0;
        end
    end

    // Pointers, occupancy and per-entry status; reset discards everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head  <= ptr_inc(head, n_commit);
            tail  <= ptr_inc(tail, n_alloc);
            count <= count + (SLOT_W+1)'(n_alloc) - (SLOT_W+1)'(n_commit);
            valid <= valid_nxt;
            done  <= done_nxt;
        end
    end

    // Result payload capture; B is written first so a same-slot A fill overrides it
    always_ff @(posedge clk) begin
        if (fill_b) begin
            wen[fillB_slot]   <= fillB_wen;
            waddr[fillB_slot] <= fillB_waddr;
            data[fillB_slot]  <= fillB_wdata;
        end
        if (fill_a) begin
            wen[fillA_slot]   <= fillA_wen;
            waddr[fillA_slot] <= fillA_waddr;
            data[fillA_slot]  <= fillA_wdata;
        end
    end
endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// tb_riscv_core_reorder_buffer: directed table and sequence checks for the reorder buffer
module tb_riscv_core_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        alloc0_req, alloc1_req;
    logic [4:0]  alloc0_slot, alloc1_slot;
    logic        rob_stall;
    logic        fillA_val, fillA_wen, fillB_val, fillB_wen;
    logic [4:0]  fillA_slot, fillA_waddr, fillB_slot, fillB_waddr;
    logic [31:0] fillA_wdata, fillB_wdata;
    logic        c1, c2, wen1, wen2;
    logic [4:0]  s1, s2, waddr1, waddr2, rd0_slot, rd1_slot;
    logic [31:0] d1, d2, rd0_data, rd1_data;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    riscv_core_reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc0_req(alloc0_req), .alloc1_req(alloc1_req),
        .alloc0_slot(alloc0_slot), .alloc1_slot(alloc1_slot), .rob_stall(rob_stall),
        .fillA_val(fillA_val), .fillA_slot(fillA_slot), .fillA_wen(fillA_wen),
        .fillA_waddr(fillA_waddr), .fillA_wdata(fillA_wdata),
        .fillB_val(fillB_val), .fillB_slot(fillB_slot), .fillB_wen(fillB_wen),
        .fillB_waddr(fillB_waddr), .fillB_wdata(fillB_wdata),
        .rob_commit_val_1(c1), .rob_commit_slot_1(s1), .rob_commit_wen_1(wen1),
        .rob_commit_waddr_1(waddr1), .rob_commit_wdata_1(d1),
        .rob_commit_val_2(c2), .rob_commit_slot_2(s2), .rob_commit_wen_2(wen2),
        .rob_commit_waddr_2(waddr2), .rob_commit_wdata_2(d2),
        .rob_rd0_slot(rd0_slot), .rob_rd1_slot(rd1_slot),
        .rob_rd0_data(rd0_data), .rob_rd1_data(rd1_data)
    );

    // Issue must never allocate while the buffer reports stall
    always @(posedge clk)
        assert (!(reset && rob_stall && (alloc0_req || alloc1_req)))
            else $error("FAIL protocol: allocation while rob_stall");

    typedef struct {
        logic        a0, a1;
        logic        fa;
        logic [4:0]  fa_slot;
        logic [31:0] fa_data;
        logic        fb;
        logic [4:0]  fb_slot;
        logic [31:0] fb_data;
        logic [4:0]  e_a0s, e_a1s;
        logic        e_stall;
        logic        e_c1;
        logic [4:0]  e_s1;
        logic [31:0] e_d1;
        logic        e_c2;
        logic [4:0]  e_s2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic a0, input logic a1, input logic fa, input logic [4:0] fas,
                         input logic [31:0] fad, input logic fb, input logic [4:0] fbs, input logic [31:0] fbd);
        alloc0_req  = a0;
        alloc1_req  = a1;
        fillA_val   = fa;
        fillA_slot  = fas;
        fillA_wdata = fad;
        fillA_waddr = fad[4:0];
        fillA_wen   = fa;
        fillB_val   = fb;
        fillB_slot  = fbs;
        fillB_wdata = fbd;
        fillB_waddr = fbd[4:0];
        fillB_wen   = fb;
    endtask

    task automatic chk_commit(input string name, input logic ec1, input logic [4:0] es1, input logic [31:0] ed1,
                              input logic ec2, input logic [4:0] es2, input logic [31:0] ed2);
        rd0_slot = es1;
        rd1_slot = es2;
        #1;
        chk({name, " c1"}, 64'(c1), 64'(ec1));
        chk({name, " c2"}, 64'(c2), 64'(ec2));
        if (ec1) chk({name, " commit1 fields"}, {s1, wen1, waddr1, d1, rd0_data}, {es1, 1'b1, ed1[4:0], ed1, ed1});
        if (ec2) chk({name, " commit2 fields"}, {s2, wen2, waddr2, d2, rd1_data}, {es2, 1'b1, ed2[4:0], ed2, ed2});
    endtask

    initial begin
        logic [4:0] s;
        //        a0 a1 fa  fas  fad      fb  fbs  fbd      a0s   a1s   st   c1  s1    d1       c2  s2    d2
        vt[0]  = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd0, 5'd0, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[1]  = '{1, 1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd0, 5'd1, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[2]  = '{0, 0, 0, 5'd0, 32'h0,  1, 5'd1, 32'h22, 5'd2, 5'd2, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[3]  = '{0, 0, 1, 5'd0, 32'h11, 0, 5'd0, 32'h0,  5'd2, 5'd2, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[4]  = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd2, 5'd2, 0,   1, 5'd0, 32'h11,  1, 5'd1, 32'h22};
        vt[5]  = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd2, 5'd2, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[6]  = '{1, 1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd2, 5'd3, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        for (int i = 7; i < 12; i++)
            vt[i] = '{0, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 5'd4, 5'd4, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0};
        vt[12] = '{0, 0, 1, 5'd2, 32'h44, 0, 5'd0, 32'h0,  5'd4, 5'd4, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[13] = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd4, 5'd4, 0,   1, 5'd2, 32'h44,  1, 5'd3, 32'h33};
        vt[14] = '{0, 1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd4, 5'd4, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[15] = '{0, 0, 1, 5'd4, 32'h55, 0, 5'd0, 32'h0,  5'd5, 5'd5, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[16] = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd5, 5'd5, 0,   1, 5'd4, 32'h55,  0, 5'd0, 32'h0};
        vt[17] = '{0, 0, 1, 5'd6, 32'h66, 0, 5'd0, 32'h0,  5'd5, 5'd5, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[18] = '{1, 1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd5, 5'd6, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[19] = '{0, 0, 1, 5'd5, 32'h77, 0, 5'd0, 32'h0,  5'd7, 5'd7, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[20] = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd7, 5'd7, 0,   1, 5'd5, 32'h77,  0, 5'd0, 32'h0};
        vt[21] = '{0, 0, 0, 5'd0, 32'h0,  1, 5'd6, 32'h88, 5'd7, 5'd7, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        vt[22] = '{0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd7, 5'd7, 0,   1, 5'd6, 32'h88,  0, 5'd0, 32'h0};
        vt[23] = '{1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd7, 5'd8, 0,   0, 5'd0, 32'h0,   0, 5'd0, 32'h0};
        rd0_slot = '0;
        rd1_slot = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset state", {c1, c2, rob_stall, alloc0_slot, alloc1_slot}, {1'b0, 1'b0, 1'b0, 5'd0, 5'd1});
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(vt[i].a0, vt[i].a1, vt[i].fa, vt[i].fa_slot, vt[i].fa_data, vt[i].fb, vt[i].fb_slot, vt[i].fb_data);
            chk_commit($sformatf("vec%0d", i), vt[i].e_c1, vt[i].e_s1, vt[i].e_d1, vt[i].e_c2, vt[i].e_s2, vt[i].e_d2);
            chk($sformatf("vec%0d alloc/stall", i), {alloc0_slot, alloc1_slot, rob_stall}, {vt[i].e_a0s, vt[i].e_a1s, vt[i].e_stall});
            step();
        end
        // head=7, one entry (slot 7) allocated; fill the buffer to 31 entries
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stall at 31 entries", {rob_stall, alloc0_slot}, {1'b1, 5'd6});
        drive(0, 0, 1, 5'd7, 32'hA7, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_commit("full head commit", 1, 5'd7, 32'hA7, 0, 5'd8, 32'h0);
        chk("still stalled before commit", 64'(rob_stall), 64'(1'b1));
        step();
        #1;
        chk("stall released at 30", {rob_stall, alloc0_slot}, {1'b0, 5'd6});
        drive(0, 0, 1, 5'd8, 32'hB8, 1, 5'd9, 32'hB9);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_commit("pre-reset pair", 1, 5'd8, 32'hB8, 1, 5'd9, 32'hB9);
        alloc0_req = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async reset drops commit", {c1, c2, rob_stall, alloc0_slot, alloc1_slot}, {1'b0, 1'b0, 1'b0, 5'd0, 5'd1});
        step();
        step();
        alloc0_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("after reset release", {c1, c2, rob_stall, alloc0_slot}, {1'b0, 1'b0, 1'b0, 5'd0});
        // one single entry, then pairs so that slots 31 and 0 retire together
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 5'd0, 32'h200, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_commit("single slot0", 1, 5'd0, 32'h200, 0, 5'd1, 32'h0);
        step();
        for (int k = 0; k < 20; k++) begin
            s = 5'(1 + 2 * k);
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("wrap alloc %0d", k), {alloc0_slot, alloc1_slot}, {s, 5'(s + 5'd1)});
            step();
            drive(0, 0, 1, s, 32'h300 + 32'(2 * k), 1, 5'(s + 5'd1), 32'h301 + 32'(2 * k));
            step();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            chk_commit($sformatf("wrap pair %0d", k), 1, s, 32'h300 + 32'(2 * k), 1, 5'(s + 5'd1), 32'h301 + 32'(2 * k));
            step();
        end
        #1;
        chk("drained", {c1, c2, rob_stall, alloc0_slot}, {1'b0, 1'b0, 1'b0, 5'd9});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
